base_sampler_ctrl: RTL



---
 rtl/base_sampler_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/base_sampler_ctrl.sv
// base_sampler_ctrl: round-robin burst sequencer that feeds a latency-1 base sampler and collects z0 into a tagged FIFO.
// Define BASE_SAMPLER_CTRL_STATS_EN to add saturating issue and randomness-stall counters.
module base_sampler_ctrl #(
   parameter int  NUM_REQ    = 2,
   parameter int  LEN_W      = 8,
   parameter int  FIFO_DEPTH = 4,
   localparam int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic                     rnd_valid_i,
   input  logic [71:0]              rnd_data_i,
   output logic                     rnd_ready_o,
   output logic [71:0]              bs_rand_o,
   input  logic [63:0]              bs_z0_i,
   output logic                     z0_valid_o,
   input  logic                     z0_ready_i,
   output logic [6:0]               z0_o,
   output logic [TAG_W-1:0]         z0_tag_o,
   output logic                     z0_last_o,
`ifdef BASE_SAMPLER_CTRL_STATS_EN
   output logic                     busy_o,
   output logic [31:0]              stat_samples_o,
   output logic [31:0]              stat_rnd_stall_o
`else
   output logic                     busy_o
`endif
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = 7 + TAG_W + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, tag_q, tag_d, gnt, idx;
   logic [LEN_W-1:0] rem_q, rem_d, gnt_len;
   logic             infl_q, infl_d, infl_last_q, infl_last_d;
   logic [TAG_W-1:0] infl_tag_q, infl_tag_d;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [EW-1:0]    head;
   logic             found, credit_ok, issue, push, pop, unused_bits;

   // Round-robin search starts one past the last grant.
   always_comb begin
      found   = 1'b0;
      gnt     = '0;
      idx     = '0;
      gnt_len = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = TAG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (TAG_W'(i) == gnt) gnt_len = req_len_i[i*LEN_W +: LEN_W];
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      tag_d       = tag_q;
      rem_d       = rem_q;
      infl_d      = 1'b0;
      infl_tag_d  = infl_tag_q;
      infl_last_d = infl_last_q;
      req_ready_o = '0;
      credit_ok   = (cnt_q + CW'(infl_q)) < CW'(FIFO_DEPTH);
      rnd_ready_o = (state_q == RUN) && credit_ok;
      issue       = rnd_ready_o && rnd_valid_i;
      if (state_q == IDLE && found && rst_n) begin
         req_ready_o = NUM_REQ'(1) << gnt;
         rr_ptr_d    = gnt;
         tag_d       = gnt;
         rem_d       = gnt_len;
         state_d     = (gnt_len != '0) ? RUN : IDLE;
      end else if (issue) begin
         infl_d      = 1'b1;
         infl_tag_d  = tag_q;
         infl_last_d = (rem_q == LEN_W'(1));
         rem_d       = rem_q - LEN_W'(1);
         state_d     = (rem_q == LEN_W'(1)) ? IDLE : RUN;
      end
   end

   // The sampler output is valid the cycle after issue, so the inflight flag is the push strobe.
   always_comb begin
      push  = infl_q;
      pop   = z0_valid_o && z0_ready_i;
      wr_d  = push ? wr_q + AW'(1) : wr_q;
      rd_d  = pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= TAG_W'(NUM_REQ - 1);
         tag_q       <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_tag_q  <= '0;
         infl_last_q <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         tag_q       <= tag_d;
         rem_q       <= rem_d;
         infl_q      <= infl_d;
         infl_tag_q  <= infl_tag_d;
         infl_last_q <= infl_last_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= {bs_z0_i[6:0], infl_tag_q, infl_last_q};

   assign head        = mem_q[rd_q];
   assign z0_valid_o  = (cnt_q != '0);
   assign z0_o        = z0_valid_o ? head[EW-1 -: 7] : '0;
   assign z0_tag_o    = z0_valid_o ? head[1 +: TAG_W] : '0;
   assign z0_last_o   = z0_valid_o && head[0];
   assign busy_o      = (state_q != IDLE) || infl_q || z0_valid_o;
   assign bs_rand_o   = rnd_data_i;
   assign unused_bits = ^bs_z0_i[63:7];

`ifdef BASE_SAMPLER_CTRL_STATS_EN
   logic [31:0] stat_samples_q, stat_samples_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_samples_d = (issue && stat_samples_q != '1) ? stat_samples_q + 32'd1 : stat_samples_q;
      stat_stall_d   = (state_q == RUN && credit_ok && !rnd_valid_i && stat_stall_q != '1) ? stat_stall_q + 32'd1 : stat_stall_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_samples_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         stat_samples_q <= stat_samples_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign stat_samples_o   = stat_samples_q;
   assign stat_rnd_stall_o = stat_stall_q;
`endif
endmodule
